// File: rtl/corescore_uart_arbiter_if.sv
// rtl/corescore_uart_arbiter_if.sv - producer, UART sink and status signals of the UART arbiter
interface corescore_uart_arbiter_if #(
  parameter int NUM_SRC = 4
) ();
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [8*NUM_SRC-1:0] i_data;
  logic [NUM_SRC-1:0]   i_valid;
  logic [NUM_SRC-1:0]   i_last;
  logic [NUM_SRC-1:0]   o_ready;
  logic [7:0]           o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic [GW-1:0]        o_grant_id;
  logic                 o_busy;
  logic                 o_overflow;

  modport master (
    input  i_data, i_valid, i_last, i_ready,
    output o_ready, o_data, o_valid, o_grant_id, o_busy, o_overflow
  );

  modport slave (
    output i_data, i_valid, i_last, i_ready,
    input  o_ready, o_data, o_valid, o_grant_id, o_busy, o_overflow
  );
endinterface

// File: rtl/corescore_uart_arbiter.sv
// rtl/corescore_uart_arbiter.sv - packet-level round-robin arbiter sharing one UART byte sink
// A granted source owns the link until its last byte or MAX_LEN bytes; optional tag byte first.
module corescore_uart_arbiter #(
  parameter int         NUM_SRC   = 4,
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] HDR_BASE  = 8'h41,
  parameter int         MAX_LEN   = 64
) (
  input logic i_clk,
  input logic i_rst,
  corescore_uart_arbiter_if.master bus
);
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t             state, state_n;
  logic [GW-1:0]      grant, grant_n;
  logic [GW-1:0]      last_grant, last_grant_n;
  logic [GW-1:0]      pick;
  logic [CW-1:0]      count, count_n;
  logic [7:0]         data_r, load_byte;
  logic               valid_r, overflow_r, overflow_n;
  logic               load, found, slot_free, xfer;
  logic [7:0]         g_data;
  logic               g_valid, g_last;
  logic [NUM_SRC-1:0] ready_v;
  int                 idx;

  assign slot_free = !valid_r || bus.i_ready;
  assign g_data    = bus.i_data[{grant, 3'b000} +: 8];
  assign g_valid   = bus.i_valid[grant];
  assign g_last    = bus.i_last[grant];
  assign xfer      = (state == DATA) && slot_free && g_valid;

  // Round-robin: first requester strictly after the previous owner, wrapping.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && bus.i_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    ready_v = '0;
    if (state == DATA && slot_free) ready_v[grant] = 1'b1;
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    count_n      = count;
    load         = 1'b0;
    load_byte    = 8'h00;
    overflow_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          state_n = HEADER_EN ? HDR : DATA;
        end
      end
      HDR: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = HDR_BASE + 8'(grant);
          state_n   = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          load      = 1'b1;
          load_byte = g_data;
          if (g_last) begin
            state_n      = IDLE;
            last_grant_n = grant;
            count_n      = '0;
          end else if ((int'(count) + 1) == MAX_LEN) begin
            // Cut here; the rest of this packet competes again as a new packet.
            state_n      = IDLE;
            last_grant_n = grant;
            count_n      = '0;
            overflow_n   = 1'b1;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_SRC - 1);
      count      <= '0;
      data_r     <= 8'h00;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      count      <= count_n;
      overflow_r <= overflow_n;
      if (load) begin
        data_r  <= load_byte;
        valid_r <= 1'b1;
      end else if (bus.i_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.o_ready    = ready_v;
  assign bus.o_data     = data_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_grant_id = grant;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_overflow = overflow_r;
endmodule
